// File: rtl/my_ram_fifo_ctl.sv
// my_ram_fifo_ctl: single-clock FIFO built around one simple dual-port RAM
// (one write port, one registered read port). Supports standard and
// first-word-fall-through read modes, any depth >= 2, a fill count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//
// Handshake: a write is taken on any cycle with i_wren=1 and o_full=0; a read
// (standard) or pop (FWFT) is taken on any cycle with i_rden=1 and o_empty=0.
// Requests made while the matching flag is set are dropped and latch
// o_ovf / o_udf respectively.
module my_ram_fifo_ctl #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    output logic              o_full,
    output logic              o_afull,
    input  logic              i_rden,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_empty,
    output logic              o_aempty,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_ovf,
    output logic              o_udf
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // Prefetch stages used only in FWFT mode: RAM read register and output register.
    logic [DATA_W-1:0] ram_q;
    logic              ram_v;
    logic              out_v;

    logic              wr;
    logic              rd;
    logic              fetch;
    logic              bypass;
    logic              out_load;
    logic [CNT_W-1:0]  held;
    logic [CNT_W-1:0]  stored;

    // Pointer advance with wrap at DEPTH-1 (depth need not be a power of two).
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Status flags decode straight from the count register.
    assign o_count  = count;
    assign o_full   = (count == CNT_W'(DEPTH));
    assign o_afull  = (count >= CNT_W'(AFULL_TH));
    assign o_aempty = (count <= CNT_W'(AEMPTY_TH));
    assign o_empty  = (FWFT != 0) ? !out_v : (count == '0);

    assign wr = i_wren & !o_full;
    assign rd = i_rden & !o_empty;

    // Read-side control: in FWFT mode a RAM fetch is issued whenever a word is
    // available (already stored, or arriving this cycle via bypass) and the RAM
    // register is free or draining into the output register.
    always_comb begin
        held     = CNT_W'(ram_v) + CNT_W'(out_v);
        stored   = count - held;
        out_load = 1'b0;
        fetch    = rd;
        bypass   = 1'b0;
        if (FWFT != 0) begin
            out_load = ram_v & (!out_v | rd);
            fetch    = ((stored != '0) | wr) & (!ram_v | out_load);
            // Nothing stored yet: the word being written is the one to fetch.
            bypass   = (stored == '0);
        end
    end

    // Count, pointers and sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_ovf  <= 1'b0;
            o_udf  <= 1'b0;
        end else begin
            if (wr && !rd)      count <= count + CNT_W'(1);
            else if (rd && !wr) count <= count - CNT_W'(1);
            if (wr)    wr_ptr <= next_ptr(wr_ptr);
            if (fetch) rd_ptr <= next_ptr(rd_ptr);
            if (i_wren && o_full)  o_ovf <= 1'b1;
            if (i_rden && o_empty) o_udf <= 1'b1;
        end
    end

    // RAM write port; contents need no reset since no word is read before written.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= i_wrdata;
    end

    // Registered read port plus the FWFT output stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ram_q    <= '0;
            ram_v    <= 1'b0;
            out_v    <= 1'b0;
            o_rddata <= '0;
        end else if (FWFT != 0) begin
            if (fetch) ram_q <= bypass ? i_wrdata : mem[rd_ptr];
            ram_v <= fetch | (ram_v & !out_load);
            if (out_load) o_rddata <= ram_q;
            out_v <= out_load | (out_v & !rd);
        end else begin
            ram_v <= 1'b0;
            out_v <= 1'b0;
            if (rd) o_rddata <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_my_ram_fifo_ctl.sv
// tb_my_ram_fifo_ctl: drives three FIFO configurations (8-deep standard,
// 5-deep standard, 8-deep FWFT) with shared stimulus and compares every
// output against a queue-based model after each clock edge.
module tb_my_ram_fifo_ctl;

    localparam int N = 3;
    localparam int DEP [N] = '{8, 5, 8};
    localparam int FWM [N] = '{0, 0, 1};
    localparam int AFT [N] = '{6, 4, 6};
    localparam int AET [N] = '{1, 1, 1};

    // Clock / reset
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic       wren = 1'b0;
    logic       rden = 1'b0;
    logic [7:0] wrdata = '0;

    logic       full_o   [N];
    logic       afull_o  [N];
    logic       empty_o  [N];
    logic       aempty_o [N];
    logic       ovf_o    [N];
    logic       udf_o    [N];
    logic [7:0] data_o   [N];
    logic [3:0] cnt0;
    logic [2:0] cnt1;
    logic [3:0] cnt2;

    my_ram_fifo_ctl #(.DATA_W(8), .DEPTH(8), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(1)) u_d0 (
        .clk(clk), .rstn(rstn), .i_wren(wren), .i_wrdata(wrdata),
        .o_full(full_o[0]), .o_afull(afull_o[0]), .i_rden(rden), .o_rddata(data_o[0]),
        .o_empty(empty_o[0]), .o_aempty(aempty_o[0]), .o_count(cnt0),
        .o_ovf(ovf_o[0]), .o_udf(udf_o[0]));

    my_ram_fifo_ctl #(.DATA_W(8), .DEPTH(5), .FWFT(0), .AFULL_TH(4), .AEMPTY_TH(1)) u_d1 (
        .clk(clk), .rstn(rstn), .i_wren(wren), .i_wrdata(wrdata),
        .o_full(full_o[1]), .o_afull(afull_o[1]), .i_rden(rden), .o_rddata(data_o[1]),
        .o_empty(empty_o[1]), .o_aempty(aempty_o[1]), .o_count(cnt1),
        .o_ovf(ovf_o[1]), .o_udf(udf_o[1]));

    my_ram_fifo_ctl #(.DATA_W(8), .DEPTH(8), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(1)) u_d2 (
        .clk(clk), .rstn(rstn), .i_wren(wren), .i_wrdata(wrdata),
        .o_full(full_o[2]), .o_afull(afull_o[2]), .i_rden(rden), .o_rddata(data_o[2]),
        .o_empty(empty_o[2]), .o_aempty(aempty_o[2]), .o_count(cnt2),
        .o_ovf(ovf_o[2]), .o_udf(udf_o[2]));

    // Scoreboard state: one expected queue per FIFO plus the edge index at
    // which each word was accepted (drives FWFT visibility).
    logic [7:0] exp_q [N][$];
    int         exp_t [N][$];
    logic [7:0] m_data  [N];
    bit         m_empty [N];
    bit         m_ovf   [N];
    bit         m_udf   [N];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned dut_cnt(input int i);
        case (i)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            exp_t[i].delete();
            m_data[i]  = '0;
            m_empty[i] = 1'b1;
            m_ovf[i]   = 1'b0;
            m_udf[i]   = 1'b0;
        end
    endtask

    // Reference behaviour at one clock edge, using the pre-edge flags.
    task automatic model_edge(input int i);
        bit wr_ok;
        bit rd_ok;
        logic [7:0] d;
        wr_ok = wren && (exp_q[i].size() < DEP[i]);
        rd_ok = rden && !m_empty[i];
        if (wren && !wr_ok)      m_ovf[i] = 1'b1;
        if (rden && m_empty[i])  m_udf[i] = 1'b1;
        if (rd_ok) begin
            d = exp_q[i].pop_front();
            void'(exp_t[i].pop_front());
            if (FWM[i] == 0) m_data[i] = d;
        end
        if (wr_ok) begin
            exp_q[i].push_back(wrdata);
            exp_t[i].push_back(cyc);
        end
        if (FWM[i] == 0) begin
            m_empty[i] = (exp_q[i].size() == 0);
        end else begin
            // A word becomes visible one full cycle after the edge that accepted it.
            m_empty[i] = !((exp_q[i].size() > 0) && (exp_t[i][0] + 1 <= cyc));
            if (!m_empty[i]) m_data[i] = exp_q[i][0];
        end
    endtask

    task automatic compare_all();
        int c;
        for (int i = 0; i < N; i++) begin
            c = exp_q[i].size();
            check($sformatf("d%0d_count", i), dut_cnt(i), c);
            check($sformatf("d%0d_full", i), full_o[i], (c == DEP[i]) ? 1 : 0);
            check($sformatf("d%0d_afull", i), afull_o[i], (c >= AFT[i]) ? 1 : 0);
            check($sformatf("d%0d_aempty", i), aempty_o[i], (c <= AET[i]) ? 1 : 0);
            check($sformatf("d%0d_empty", i), empty_o[i], m_empty[i]);
            check($sformatf("d%0d_ovf", i), ovf_o[i], m_ovf[i]);
            check($sformatf("d%0d_udf", i), udf_o[i], m_udf[i]);
            if (FWM[i] == 0 || !m_empty[i])
                check($sformatf("d%0d_data", i), data_o[i], m_data[i]);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        cyc++;
        for (int i = 0; i < N; i++) model_edge(i);
        #1;
        compare_all();
    endtask

    task automatic drive(input bit w, input bit r, input logic [7:0] d);
        wren   = w;
        rden   = r;
        wrdata = d;
        step();
    endtask

    // Asynchronous assertion mid-cycle, outputs checked before the next edge.
    task automatic do_reset();
        rstn = 1'b0;
        wren = 1'b0;
        rden = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    int wr_pct;

    initial begin
        do_reset();

        // Fill then drain: 0x01..0x08, overflow on the 9th write, underflow after.
        for (int k = 1; k <= 8; k++) drive(1'b1, 1'b0, 8'(k));
        check("fill_full_d0", full_o[0], 1);
        check("fill_cnt_d0", dut_cnt(0), 8);
        drive(1'b1, 1'b0, 8'hEE);
        check("ovf_sticky_d0", ovf_o[0], 1);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 1'b1, 8'h00);
            check("drain_order_d0", data_o[0], k);
        end
        check("drain_empty_d0", empty_o[0], 1);
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        check("udf_sticky_d0", udf_o[0], 1);
        check("udf_data_hold_d0", data_o[0], 8);
        do_reset();

        // FWFT latency: one write, visible two cycles later.
        drive(1'b1, 1'b0, 8'hA5);
        check("fwft_lat_n1_empty", empty_o[2], 1);
        drive(1'b0, 1'b0, 8'h00);
        check("fwft_lat_n2_empty", empty_o[2], 0);
        check("fwft_lat_n2_data", data_o[2], 8'hA5);
        drive(1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 8'h10 + 8'(k));
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            check("fwft_burst_data", data_o[2], 8'h10 + 8'(k));
            drive(1'b0, 1'b1, 8'h00);
        end
        check("fwft_burst_empty", empty_o[2], 1);

        // Simultaneous write and read at count 3.
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 8'($urandom_range(255)));
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'h77);
        check("wr_rd_cnt3_d0", dut_cnt(0), 3);

        // Async reset mid-burst.
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 8'($urandom_range(255)));
        #2;
        do_reset();

        // Randomised traffic alternating fill-heavy and drain-heavy phases.
        for (int p = 0; p < 8; p++) begin
            wr_pct = (p % 2 == 0) ? 80 : 25;
            for (int k = 0; k < 50; k++)
                drive($urandom_range(99) < wr_pct, $urandom_range(99) < (100 - wr_pct),
                      8'($urandom_range(255)));
        end
        do_reset();
        for (int k = 0; k < 200; k++)
            drive($urandom_range(1) == 1, $urandom_range(1) == 1, 8'($urandom_range(255)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
